// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back commit unit.
package wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // RV32I load encodings; other funct3 values behave as LW
    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_funct3_e;

    // Raw load return as captured from memory, extended only on commit
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic [1:0]        byte_off;
        logic [XLEN-1:0]   rdata;
    } lq_entry_t;

    // Pick the addressed byte/halfword and sign- or zero-extend it
    function automatic logic [XLEN-1:0] load_extend(input lq_entry_t e);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (e.byte_off)
            2'd0:    b = e.rdata[7:0];
            2'd1:    b = e.rdata[15:8];
            2'd2:    b = e.rdata[23:16];
            default: b = e.rdata[31:24];
        endcase
        h = e.byte_off[1] ? e.rdata[31:16] : e.rdata[15:0];
        case (e.funct3)
            LD_LB:   r = {{(XLEN-8){b[7]}}, b};
            LD_LH:   r = {{(XLEN-16){h[15]}}, h};
            LD_LBU:  r = {{(XLEN-8){1'b0}}, b};
            LD_LHU:  r = {{(XLEN-16){1'b0}}, h};
            default: r = e.rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// Producer-side handshakes and register-file write port of the commit unit.
// master: execute/memory side plus write-port observer; slave: commit unit.
interface wb_commit_unit_if #(
    parameter int unsigned LQ_DEPTH = 4
);
    localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

    logic                     alu_valid;
    logic                     alu_ready;
    logic [4:0]               alu_rd;
    logic [wb_pkg::XLEN-1:0]  alu_result;

    logic                     ld_valid;
    logic                     ld_ready;
    logic [4:0]               ld_rd;
    logic [2:0]               ld_funct3;
    logic [1:0]               ld_byte_off;
    logic [wb_pkg::XLEN-1:0]  ld_rdata;

    logic                     reg_write_enable;
    logic [4:0]               write_reg;
    logic [wb_pkg::XLEN-1:0]  write_back_data;
    logic [CW-1:0]            lq_count;

    modport master (
        output alu_valid, alu_rd, alu_result,
        output ld_valid, ld_rd, ld_funct3, ld_byte_off, ld_rdata,
        input  alu_ready, ld_ready,
        input  reg_write_enable, write_reg, write_back_data, lq_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  ld_valid, ld_rd, ld_funct3, ld_byte_off, ld_rdata,
        output alu_ready, ld_ready,
        output reg_write_enable, write_reg, write_back_data, lq_count
    );
endinterface

// File: rtl/wb_load_queue.sv
// Synchronous FIFO of raw load returns. Push while full is allowed only
// together with a pop in the same cycle.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  lq_entry_t                 push_data,
    input  logic                      pop,
    output lq_entry_t                 pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    lq_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit unit: arbitrates ALU results and queued load returns
// onto the single register-file write port, one commit per cycle.
// Optional feature macro: WB_LQ_BYPASS_EN (idle-unit loads skip the queue).
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    wb_commit_unit_if.slave     bus
);
    localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

    lq_entry_t          in_entry;
    lq_entry_t          head;
    logic               q_full;
    logic               q_empty;
    logic [CW-1:0]      q_count;
    logic               deq;
    logic               alu_fire;
    logic               ld_fire;
    logic               bypass;
    logic               push;

    logic               commit_we_c;
    logic [4:0]         commit_rd_c;
    logic [XLEN-1:0]    commit_data_c;

    logic               we_q;
    logic [4:0]         wreg_q;
    logic [XLEN-1:0]    wdata_q;

    assign in_entry = '{rd: bus.ld_rd, funct3: bus.ld_funct3,
                        byte_off: bus.ld_byte_off, rdata: bus.ld_rdata};

    // A full queue always wins; otherwise ALU has priority over queued loads
    assign deq      = !q_empty && (q_full || !bus.alu_valid);
    assign alu_fire = bus.alu_valid && !q_full;
    assign ld_fire  = bus.ld_valid && bus.ld_ready;

`ifdef WB_LQ_BYPASS_EN
    assign bypass   = ld_fire && q_empty && !bus.alu_valid;
`else
    assign bypass   = 1'b0;
`endif

    assign push          = ld_fire && !bypass;
    assign bus.alu_ready = !q_full;
    assign bus.ld_ready  = !q_full || deq;

    wb_load_queue #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_entry),
        .pop       (deq),
        .pop_data  (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Select this cycle's commit source; writes to x0 are consumed silently
    always_comb begin
        commit_we_c   = 1'b0;
        commit_rd_c   = '0;
        commit_data_c = '0;
        if (deq) begin
            commit_we_c   = (head.rd != '0);
            commit_rd_c   = head.rd;
            commit_data_c = load_extend(head);
        end else if (alu_fire) begin
            commit_we_c   = (bus.alu_rd != '0);
            commit_rd_c   = bus.alu_rd;
            commit_data_c = bus.alu_result;
        end else if (bypass) begin
            commit_we_c   = (bus.ld_rd != '0);
            commit_rd_c   = bus.ld_rd;
            commit_data_c = load_extend(in_entry);
        end
        if (!commit_we_c) begin
            commit_rd_c   = '0;
            commit_data_c = '0;
        end
    end

    // Registered write port; address/data read as zero when not writing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= commit_we_c;
            wreg_q  <= commit_rd_c;
            wdata_q <= commit_data_c;
        end
    end

    assign bus.reg_write_enable = we_q;
    assign bus.write_reg        = wreg_q;
    assign bus.write_back_data  = wdata_q;
    assign bus.lq_count         = q_count;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: stimulus pushes expected writes per
// source, a negedge monitor pops and compares every register-file write.
module tb_wb_commit_unit;

    localparam int unsigned LQD = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t alu_q[$];
    exp_t ld_q[$];

    wb_commit_unit_if #(.LQ_DEPTH(LQD)) bus ();

    wb_commit_unit #(.LQ_DEPTH(LQD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_alu_rd(input logic [4:0] rd);
        return (rd == 5'd5) || rd[4];
    endfunction

    // Monitor: route each write to its source queue by destination register
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.reg_write_enable === 1'b1) begin
            if (is_alu_rd(bus.write_reg) ? (alu_q.size() == 0) : (ld_q.size() == 0)) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got x%0d=0x%08h expected no write at %0t",
                         bus.write_reg, bus.write_back_data, $time);
            end else begin
                e = is_alu_rd(bus.write_reg) ? alu_q.pop_front() : ld_q.pop_front();
                check("write_reg", 32'(bus.write_reg), 32'(e.rd));
                check("write_data", bus.write_back_data, e.data);
            end
        end
    end

    // Offer one ALU result and hold it until accepted; returns at edge+1
    task automatic send_alu(input logic [4:0] rd, input logic [31:0] d,
                            input bit expect_write, output int waits);
        bit ok;
        waits = 0;
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = rd;
        bus.alu_result = d;
        forever begin
            @(negedge clk);
            ok = bus.alu_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waits++;
            if (waits > 50) begin
                check("alu_accept_timeout", 32'(0), 32'(1));
                break;
            end
        end
        if (ok && expect_write && rd != 5'd0) alu_q.push_back('{rd, d});
        bus.alu_valid = 1'b0;
    endtask

    // Offer one load return and hold it until accepted; returns at edge+1
    task automatic send_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] rdata, input logic [31:0] exp_data);
        bit ok;
        int waits;
        waits = 0;
        bus.ld_valid    = 1'b1;
        bus.ld_rd       = rd;
        bus.ld_funct3   = f3;
        bus.ld_byte_off = off;
        bus.ld_rdata    = rdata;
        forever begin
            @(negedge clk);
            ok = bus.ld_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waits++;
            if (waits > 50) begin
                check("ld_accept_timeout", 32'(0), 32'(1));
                break;
            end
        end
        if (ok && rd != 5'd0) ld_q.push_back('{rd, exp_data});
        bus.ld_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hard stop in case anything above never returns
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int max_cnt;
        bit stall_seen;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_result = '0;
        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_funct3 = '0;
        bus.ld_byte_off = '0; bus.ld_rdata = '0;

        // Reset state
        idle(2);
        check("rst_we", 32'(bus.reg_write_enable), 32'(0));
        check("rst_wreg", 32'(bus.write_reg), 32'(0));
        check("rst_wdata", bus.write_back_data, 32'h0);
        check("rst_lq_count", 32'(bus.lq_count), 32'(0));
        check("rst_alu_ready", 32'(bus.alu_ready), 32'(1));
        rst = 1'b0;
        idle(2);

        // ALU x5 write: visible the cycle after acceptance, for one cycle
        send_alu(5'd5, 32'hDEADBEEF, 1, w);
        check("alu_we_n1", 32'(bus.reg_write_enable), 32'(1));
        check("alu_wreg_n1", 32'(bus.write_reg), 32'(5));
        check("alu_wdata_n1", bus.write_back_data, 32'hDEADBEEF);
        idle(1);
        check("alu_we_n2", 32'(bus.reg_write_enable), 32'(0));

        // ALU to x0: accepted immediately, no write
        send_alu(5'd0, 32'h12345678, 1, w);
        check("alu_x0_waits", 32'(w), 32'(0));
        check("alu_x0_we", 32'(bus.reg_write_enable), 32'(0));
        idle(1);
        check("alu_x0_we2", 32'(bus.reg_write_enable), 32'(0));

        // Load extraction vectors
        send_ld(5'd7, 3'b000, 2'd2, 32'h12F45678, 32'hFFFFFFF4); idle(3); // LB
        send_ld(5'd7, 3'b100, 2'd2, 32'h12F45678, 32'h000000F4); idle(3); // LBU
        send_ld(5'd7, 3'b101, 2'd2, 32'h12F45678, 32'h000012F4); idle(3); // LHU
        send_ld(5'd8, 3'b000, 2'd0, 32'h12F45678, 32'h00000078); idle(3); // LB b0
        send_ld(5'd8, 3'b000, 2'd3, 32'h12F45678, 32'h00000012); idle(3); // LB b3
        send_ld(5'd8, 3'b100, 2'd1, 32'h12F45678, 32'h00000056); idle(3); // LBU b1
        send_ld(5'd6, 3'b001, 2'd1, 32'h80017FFF, 32'h00007FFF); idle(3); // LH off[0] ignored
        send_ld(5'd6, 3'b001, 2'd3, 32'h80017FFF, 32'hFFFF8001); idle(3); // LH hi
        send_ld(5'd6, 3'b010, 2'd3, 32'hCAFEF00D, 32'hCAFEF00D); idle(3); // LW off ignored
        send_ld(5'd6, 3'b011, 2'd1, 32'h80017FFF, 32'h80017FFF); idle(3); // undefined -> LW
        send_ld(5'd0, 3'b010, 2'd0, 32'h55555555, 32'h0);        idle(3); // x0 load

        // ALU every cycle while five loads arrive back to back
        max_cnt = 0;
        stall_seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_alu(5'(16 + i), 32'hA0000000 + 32'(i), 1, w);
            end
            begin
                send_ld(5'd1, 3'b010, 2'd0, 32'h10000001, 32'h10000001);
                send_ld(5'd2, 3'b010, 2'd0, 32'h10000002, 32'h10000002);
                send_ld(5'd3, 3'b010, 2'd0, 32'h10000003, 32'h10000003);
                send_ld(5'd4, 3'b010, 2'd0, 32'h10000004, 32'h10000004);
                send_ld(5'd6, 3'b000, 2'd1, 32'h0000FF00, 32'hFFFFFFFF);
            end
            begin
                repeat (25) begin
                    @(negedge clk);
                    if (int'(bus.lq_count) > max_cnt) max_cnt = int'(bus.lq_count);
                    if (bus.alu_valid && !bus.alu_ready) stall_seen = 1'b1;
                end
            end
        join
        idle(10);
        check("burst_max_lq_count", 32'(max_cnt), 32'(LQD));
        check("burst_alu_stall", 32'(stall_seen), 32'(1));
        check("burst_alu_drained", 32'(alu_q.size()), 32'(0));
        check("burst_ld_drained", 32'(ld_q.size()), 32'(0));

        // Fill queue to three behind x0 ALU traffic, then reset mid-stream
        fork
            begin
                for (int i = 0; i < 3; i++) send_alu(5'd0, 32'hBBBB0000 + 32'(i), 1, w);
            end
            begin
                send_ld(5'd10, 3'b010, 2'd0, 32'h0000000A, 32'h0000000A);
                send_ld(5'd11, 3'b010, 2'd0, 32'h0000000B, 32'h0000000B);
                send_ld(5'd12, 3'b010, 2'd0, 32'h0000000C, 32'h0000000C);
            end
        join
        check("prerst_lq_count", 32'(bus.lq_count), 32'(3));
        send_alu(5'd20, 32'h5555AAAA, 0, w);
        check("prerst_we", 32'(bus.reg_write_enable), 32'(1));
        check("prerst_wdata", bus.write_back_data, 32'h5555AAAA);
        rst = 1'b1;
        #1;
        check("midrst_we", 32'(bus.reg_write_enable), 32'(0));
        check("midrst_wreg", 32'(bus.write_reg), 32'(0));
        check("midrst_wdata", bus.write_back_data, 32'h0);
        check("midrst_lq_count", 32'(bus.lq_count), 32'(0));
        ld_q.delete();
        idle(2);
        rst = 1'b0;
        idle(10);
        check("postrst_lq_count", 32'(bus.lq_count), 32'(0));

        // Single LW into an idle unit: bypass writes at N+1, queue path at N+2
        send_ld(5'd9, 3'b010, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D);
`ifdef WB_LQ_BYPASS_EN
        check("lw_we_n1", 32'(bus.reg_write_enable), 32'(1));
        check("lw_wdata_n1", bus.write_back_data, 32'hCAFEF00D);
        check("lw_lq_count_n1", 32'(bus.lq_count), 32'(0));
        idle(1);
        check("lw_we_n2", 32'(bus.reg_write_enable), 32'(0));
`else
        check("lw_we_n1", 32'(bus.reg_write_enable), 32'(0));
        check("lw_lq_count_n1", 32'(bus.lq_count), 32'(1));
        idle(1);
        check("lw_we_n2", 32'(bus.reg_write_enable), 32'(1));
        check("lw_wreg_n2", 32'(bus.write_reg), 32'(9));
        check("lw_wdata_n2", bus.write_back_data, 32'hCAFEF00D);
        check("lw_lq_count_n2", 32'(bus.lq_count), 32'(0));
`endif
        idle(5);
        check("final_alu_q_empty", 32'(alu_q.size()), 32'(0));
        check("final_ld_q_empty", 32'(ld_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
